batcharger_meas_seq: RTL and testbench
======================================

BATCHARGER_MEAS_SEQ -- requirements
Module: batcharger_meas_seq

Interface
REQ-001 The block SHALL have one clock `clk` and one reset `rstz`; reset SHALL be asynchronous and active-low.
REQ-002 Parameter `AVG_LOG2`, default 2, SHALL set the number of samples averaged per channel to 2^AVG_LOG2 (legal range 0..4).
REQ-003 Parameter `SETTLE`, default 2, SHALL set the mux settling cycles after each `adc_sel` change (legal range 0..15).
REQ-004 Parameter `TIMEOUT`, default 63, SHALL set the maximum cycles spent waiting for `adc_eoc` (legal range 1..255).
REQ-005 Port `clk`: input, 1 bit, digital clock.
REQ-006 Port `rstz`: input, 1 bit, asynchronous active-low reset.
REQ-007 Port `en`: input, 1 bit, block enable.
REQ-008 Port `vmeasen`: input, 1 bit, battery-voltage channel enable from the charge controller.
REQ-009 Port `imeasen`: input, 1 bit, battery-current channel enable from the charge controller.
REQ-010 Port `tmeasen`: input, 1 bit, temperature channel enable from the charge controller.
REQ-011 Port `adc_eoc`: input, 1 bit, ADC end-of-conversion pulse.
REQ-012 Port `adc_data`: input, 8 bits, ADC result; valid only while `adc_eoc`=1.
REQ-013 Port `adc_start`: output, 1 bit, one-cycle conversion start.
REQ-014 Port `adc_sel`: output, 2 bits, analog mux select: 00=vbat, 01=ibat, 10=vtemp; 11 SHALL never be driven.
REQ-015 Ports `vbat_q`, `ibat_q`, `vtemp_q`: outputs, 8 bits each, averaged result per channel.
REQ-016 Port `upd`: output, 3 bits, one-cycle update strobe: bit0=vbat, bit1=ibat, bit2=vtemp.
REQ-017 Port `adc_err`: output, 1 bit, conversion-timeout flag.

Function
REQ-018 The FSM SHALL have the states IDLE, SETTLE, CONV, WAIT and NEXT.
REQ-019 IDLE SHALL go to SETTLE when `en`=1 and at least one channel enable is 1; the channel chosen SHALL be the first enabled one at or after the round-robin pointer, in the order V, I, T, wrapping.
REQ-020 On entry to SETTLE, `adc_sel` SHALL update to the chosen channel.
REQ-021 SETTLE SHALL last exactly `SETTLE` cycles before going to CONV; when `SETTLE`=0 the state SHALL be skipped.
REQ-022 CONV SHALL assert `adc_start`=1 for exactly one cycle, clear the timeout counter, and go to WAIT.
REQ-023 WAIT with `adc_eoc`=1 SHALL add `adc_data` to an accumulator of 8+AVG_LOG2 bits, which never overflows.
REQ-024 After that accumulation in WAIT, the block SHALL go back to CONV (no re-settle) if fewer than 2^AVG_LOG2 samples have been taken.
REQ-025 Otherwise, on the same edge, the block SHALL write accumulator>>AVG_LOG2 (truncated) to the channel register, pulse the matching `upd` bit for one cycle, and go to NEXT.
REQ-026 `adc_eoc` outside WAIT SHALL be ignored; an `adc_eoc` on the same cycle as `adc_start` SHALL be ignored.
REQ-027 In WAIT, after `TIMEOUT` cycles without `adc_eoc`, the block SHALL set `adc_err`=1, discard the accumulator, leave the channel register unchanged, assert no `upd`, and go to NEXT.
REQ-028 `adc_err` SHALL stay set until the next `upd` pulse on any channel, then clear on the same edge.
REQ-029 NEXT SHALL advance the pointer to the channel after the one just serviced, then go to SETTLE for the next enabled channel, or to IDLE if none is enabled or `en`=0.
REQ-030 Channel enables SHALL be sampled only in IDLE and NEXT; deasserting a channel's enable mid-conversion SHALL NOT abort that channel.
REQ-031 `en`=0 in any non-IDLE state SHALL send the FSM to IDLE on the next edge, discard the accumulator, and assert no `upd`; results and `adc_err` SHALL be retained.
REQ-032 With a single enabled channel, the block SHALL re-service that channel continuously, including the SETTLE delay each pass.
REQ-033 `upd` SHALL have at most one bit set in any cycle.
REQ-034 Result registers SHALL change only on their `upd` cycle.

Reset
REQ-035 While `rstz`=0, all outputs SHALL be 0, the state SHALL be IDLE, the pointer SHALL be V, and the accumulator and counters SHALL be 0, regardless of `clk`.
REQ-036 Reset asserted mid-conversion SHALL abort with no `upd`; after release, operation SHALL resume from IDLE on the first edge with `rstz`=1.

Verification
REQ-037 Defaults; `en`=1, `vmeasen`=1 only; ADC model returns 0x80,0x81,0x82,0x83 with `adc_eoc` 3 cycles after each `adc_start` -> `vbat_q`=0x81, `upd`=001 for one cycle, `adc_sel`=00 throughout.
REQ-038 `imeasen`=1, `tmeasen`=1, `vmeasen`=0 (CV-mode pattern) -> `adc_sel` alternates 01,10,01,... and never takes 00 or 11; `upd` alternates 010/100; 2 idle cycles precede every first `adc_start` of a channel.
REQ-039 ADC never returns `adc_eoc` on vbat -> `adc_err`=1 exactly 63 cycles after `adc_start`, `vbat_q` unchanged, then the sequencer moves to the next channel; the next good conversion clears `adc_err`.
REQ-040 `en` dropped during the third sample of ibat -> IDLE next cycle, no `upd`, `ibat_q` keeps its prior value; re-enable restarts ibat from 4 fresh samples.
REQ-041 `rstz` pulsed low for less than one clock period mid-WAIT -> all outputs 0 immediately, pointer=V, first conversion after release uses `adc_sel`=00.
REQ-042 All samples 0xFF with `AVG_LOG2`=4 -> result 0xFF (no accumulator overflow); `AVG_LOG2`=0 -> each single sample is passed through unchanged.

Source files
------------

// File: rtl/batcharger_meas_seq.sv
// Battery-charger measurement sequencer: round-robins V/I/T through one shared ADC,
// averaging 2^AVG_LOG2 conversions per channel with mux settling and an EOC timeout.
module batcharger_meas_seq #(
  parameter int AVG_LOG2 = 2,
  parameter int SETTLE   = 2,
  parameter int TIMEOUT  = 63
) (
  input  logic       clk,
  input  logic       rstz,
  input  logic       en,
  input  logic       vmeasen,
  input  logic       imeasen,
  input  logic       tmeasen,
  input  logic       adc_eoc,
  input  logic [7:0] adc_data,
  output logic       adc_start,
  output logic [1:0] adc_sel,
  output logic [7:0] vbat_q,
  output logic [7:0] ibat_q,
  output logic [7:0] vtemp_q,
  output logic [2:0] upd,
  output logic       adc_err
);
  localparam int         ACC_W   = 8 + AVG_LOG2;
  localparam logic [4:0] NS_LAST = 5'((1 << AVG_LOG2) - 1);
  localparam logic [3:0] ST_LAST = 4'((SETTLE > 0) ? SETTLE - 1 : 0);
  // the timeout window includes the start cycle, so WAIT gives up one count early
  localparam logic [7:0] TO_LAST = 8'((TIMEOUT > 1) ? TIMEOUT - 2 : 0);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_CONV, S_WAIT, S_NEXT} state_t;
  state_t r_state, w_state_nxt;

  logic [1:0]       r_sel, r_ptr;
  logic [3:0]       r_scnt;
  logic [7:0]       r_tcnt;
  logic [4:0]       r_ncnt;
  logic [ACC_W-1:0] r_acc;
  logic [7:0]       r_vq, r_iq, r_tq;
  logic [2:0]       r_upd;
  logic             r_err;

  logic [2:0]       w_men;
  logic [1:0]       w_ptr_adv, w_base, w_pick;
  logic             w_found, w_go, w_abort, w_sample, w_last, w_tout;
  logic [ACC_W-1:0] w_sum;
  logic [7:0]       w_avg;

  assign w_men     = {tmeasen, imeasen, vmeasen};
  assign w_ptr_adv = (r_sel == 2'd2) ? 2'd0 : r_sel + 2'd1;
  assign w_base    = (r_state == S_NEXT) ? w_ptr_adv : r_ptr;
  assign w_abort   = !en && (r_state != S_IDLE);
  assign w_sample  = (r_state == S_WAIT) && adc_eoc;
  assign w_last    = (r_ncnt == NS_LAST);
  assign w_tout    = (r_state == S_WAIT) && !adc_eoc && (r_tcnt >= TO_LAST);
  assign w_sum     = r_acc + ACC_W'(adc_data);
  assign w_avg     = w_sum[ACC_W-1:AVG_LOG2];

  // first enabled channel at or after w_base (V,I,T order, wrapping)
  always_comb begin
    logic [2:0] t;
    t       = 3'd0;
    w_pick  = w_base;
    w_found = 1'b0;
    for (int k = 2; k >= 0; k--) begin
      t = {1'b0, w_base} + 3'(k);
      if (t >= 3'd3) t = t - 3'd3;
      if (w_men[t[1:0]]) begin
        w_pick  = t[1:0];
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_go        = 1'b0;
    case (r_state)
      S_IDLE:   w_go = en && w_found;
      S_SETTLE: if (r_scnt == ST_LAST) w_state_nxt = S_CONV;
      S_CONV:   w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_sample)    w_state_nxt = w_last ? S_NEXT : S_CONV;
        else if (w_tout) w_state_nxt = S_NEXT;
      end
      S_NEXT: begin
        w_go = en && w_found;
        if (!w_go) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_go) w_state_nxt = (SETTLE == 0) ? S_CONV : S_SETTLE;
    if (w_abort) begin
      w_state_nxt = S_IDLE;
      w_go        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      r_sel  <= 2'd0;
      r_ptr  <= 2'd0;
      r_scnt <= '0;
      r_tcnt <= '0;
      r_ncnt <= '0;
      r_acc  <= '0;
      r_vq   <= '0;
      r_iq   <= '0;
      r_tq   <= '0;
      r_upd  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_upd <= 3'b000;
      if (r_state == S_NEXT) r_ptr <= w_ptr_adv;
      if (w_abort) begin
        r_acc  <= '0;
        r_ncnt <= '0;
      end else if (w_go) begin
        r_sel  <= w_pick;
        r_scnt <= '0;
        r_acc  <= '0;
        r_ncnt <= '0;
      end else begin
        case (r_state)
          S_SETTLE: r_scnt <= r_scnt + 4'd1;
          S_CONV:   r_tcnt <= '0;
          S_WAIT: begin
            if (w_sample) begin
              if (w_last) begin
                r_acc  <= '0;
                r_ncnt <= '0;
                r_err  <= 1'b0;
                r_upd  <= 3'b001 << r_sel;
                case (r_sel)
                  2'd0:    r_vq <= w_avg;
                  2'd1:    r_iq <= w_avg;
                  default: r_tq <= w_avg;
                endcase
              end else begin
                r_acc  <= w_sum;
                r_ncnt <= r_ncnt + 5'd1;
              end
            end else if (w_tout) begin
              r_err  <= 1'b1;
              r_acc  <= '0;
              r_ncnt <= '0;
            end else begin
              r_tcnt <= r_tcnt + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign adc_start = (r_state == S_CONV);
  assign adc_sel   = r_sel;
  assign vbat_q    = r_vq;
  assign ibat_q    = r_iq;
  assign vtemp_q   = r_tq;
  assign upd       = r_upd;
  assign adc_err   = r_err;
endmodule

// File: tb/tb_batcharger_meas_seq.sv
// Bench for batcharger_meas_seq: an ADC model feeds samples and pushes expected
// channel averages into a scoreboard that the scenario tasks pop on each upd.
module tb_batcharger_meas_seq;
  logic clk = 1'b0, rstz = 1'b0;
  logic en = 1'b0, en4 = 1'b0, en0 = 1'b0;
  logic vm = 1'b0, im = 1'b0, tm = 1'b0;
  logic eoc = 1'b0;
  logic [7:0] data = 8'h00;
  logic st, st4, st0;
  logic [1:0] sel, sel4, sel0;
  logic [7:0] vq, iq, tq, vq4, iq4, tq4, vq0, iq0, tq0;
  logic [2:0] upd, upd4, upd0;
  logic err, err4, err0;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  batcharger_meas_seq dut (
    .clk(clk), .rstz(rstz), .en(en), .vmeasen(vm), .imeasen(im), .tmeasen(tm),
    .adc_eoc(eoc), .adc_data(data), .adc_start(st), .adc_sel(sel),
    .vbat_q(vq), .ibat_q(iq), .vtemp_q(tq), .upd(upd), .adc_err(err));

  batcharger_meas_seq #(.AVG_LOG2(4)) dut4 (
    .clk(clk), .rstz(rstz), .en(en4), .vmeasen(vm), .imeasen(im), .tmeasen(tm),
    .adc_eoc(eoc), .adc_data(data), .adc_start(st4), .adc_sel(sel4),
    .vbat_q(vq4), .ibat_q(iq4), .vtemp_q(tq4), .upd(upd4), .adc_err(err4));

  batcharger_meas_seq #(.AVG_LOG2(0)) dut0 (
    .clk(clk), .rstz(rstz), .en(en0), .vmeasen(vm), .imeasen(im), .tmeasen(tm),
    .adc_eoc(eoc), .adc_data(data), .adc_start(st0), .adc_sel(sel0),
    .vbat_q(vq0), .ibat_q(iq0), .vtemp_q(tq0), .upd(upd0), .adc_err(err0));

  typedef struct packed { logic [1:0] ch; logic [7:0] val; } exp_t;
  exp_t sb[$];

  int dut_sel = 0, mode = 0;
  logic mute_v = 1'b0, m_clr = 1'b0;
  logic [1:0] m_ch = 2'd0;
  int m_sum = 0, m_n = 0, m_k = 0, cd = 0;
  logic a_st;
  logic [1:0] a_sel;
  int a_avg;

  always_comb begin
    a_st = st; a_sel = sel; a_avg = 2;
    if (dut_sel == 1) begin a_st = st4; a_sel = sel4; a_avg = 4; end
    else if (dut_sel == 2) begin a_st = st0; a_sel = sel0; a_avg = 0; end
  end

  function automatic logic [7:0] sample_val(int md, int n, int k);
    if (md == 0) return 8'(8'h80 + n);
    if (md == 1) return 8'hFF;
    return 8'(k * 37 + 11);
  endfunction

  // ADC model: eoc lands 3 cycles after the start cycle
  always @(posedge clk) begin
    eoc <= 1'b0;
    if (m_clr) begin
      m_sum <= 0; m_n <= 0; cd <= 0;
    end else if (a_st) begin
      cd <= 2;
      if (a_sel != m_ch) begin m_sum <= 0; m_n <= 0; m_ch <= a_sel; end
    end else if (cd != 0) begin
      cd <= cd - 1;
      if (cd == 1 && !(mute_v && m_ch == 2'd0)) begin
        eoc  <= 1'b1;
        data <= sample_val(mode, m_n, m_k);
        m_k  <= m_k + 1;
        if (m_n + 1 == (1 << a_avg)) begin
          sb.push_back('{m_ch, 8'((m_sum + int'(sample_val(mode, m_n, m_k))) >> a_avg)});
          m_sum <= 0; m_n <= 0;
        end else begin
          m_sum <= m_sum + int'(sample_val(mode, m_n, m_k));
          m_n   <= m_n + 1;
        end
      end
    end
  end

  task automatic clr_model();
    m_clr = 1'b1;
    @(negedge clk);
    m_clr = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    rstz = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({st, sel, upd, err} !== 7'b0) begin
      failures++; $display("FAIL reset_ctl got=%b exp=0", {st, sel, upd, err});
    end
    checks++;
    if ({vq, iq, tq} !== 24'h0) begin
      failures++; $display("FAIL reset_results got=%h exp=0", {vq, iq, tq});
    end
    checks++;
    if ({st4, sel4, vq4, iq4, tq4, upd4, err4, st0, sel0, vq0, iq0, tq0, upd0, err0} !== '0) begin
      failures++; $display("FAIL reset_aux nonzero outputs on parameter variants");
    end
    rstz = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (st !== 1'b0 || upd !== 3'b0) begin
      failures++; $display("FAIL idle_disabled got st=%b upd=%b exp 0", st, upd);
    end
  endtask

  task automatic test_vbat();
    exp_t e; bit got; int bad;
    sb.delete(); mode = 0; dut_sel = 0; vm = 1; im = 0; tm = 0; en = 1;
    got = 0; bad = 0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (n > 0 && sel !== 2'b00) bad++;
      if (upd !== 3'b000) got = 1;
    end
    checks++;
    if (!got) begin failures++; $display("FAIL vbat_upd_timeout got none exp upd"); end
    else begin
      checks++;
      if (upd !== 3'b001) begin failures++; $display("FAIL vbat_upd got=%b exp=001", upd); end
      checks++;
      if (vq !== 8'h81) begin failures++; $display("FAIL vbat_q got=%h exp=81", vq); end
      checks++;
      if (sb.size() == 0) begin failures++; $display("FAIL vbat_sb got empty exp entry"); end
      else begin
        e = sb.pop_front();
        checks++;
        if (vq !== e.val || e.ch !== 2'd0) begin
          failures++; $display("FAIL vbat_sb_val got=%h exp=%h ch=%0d", vq, e.val, e.ch);
        end
      end
      @(negedge clk);
      checks++;
      if (upd !== 3'b000) begin failures++; $display("FAIL vbat_upd_pulse got=%b exp=000", upd); end
    end
    en = 0;
    repeat (4) @(negedge clk);
    checks++;
    if (bad != 0 || sel !== 2'b00) begin failures++; $display("FAIL vbat_sel got=%0d bad exp 0", bad); end
    clr_model();
  endtask

  task automatic test_timeout();
    exp_t e; int t_err, upd_bad; bit found, got, prev_err;
    logic [7:0] v_prev;
    v_prev = vq;
    sb.delete(); mode = 0; vm = 1; im = 1; tm = 0; mute_v = 1; en = 1;
    found = 0;
    for (int n = 0; n < 400 && !found; n++) begin
      @(negedge clk);
      if (upd !== 3'b000 && sb.size() != 0) e = sb.pop_front();
      if (st === 1'b1 && sel === 2'b00) found = 1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL tmo_start got none exp vbat start"); end
    t_err = -1; upd_bad = 0;
    for (int n = 1; n < 200 && found && t_err < 0; n++) begin
      @(negedge clk);
      if (upd !== 3'b000) upd_bad++;
      if (err === 1'b1) t_err = n;
    end
    checks++;
    if (t_err != 63) begin failures++; $display("FAIL tmo_latency got=%0d exp=63", t_err); end
    checks++;
    if (upd_bad != 0 || vq !== v_prev) begin
      failures++; $display("FAIL tmo_no_update got vq=%h upds=%0d exp vq=%h upds=0", vq, upd_bad, v_prev);
    end
    @(negedge clk);
    checks++;
    if (sel !== 2'b01) begin failures++; $display("FAIL tmo_next_ch got=%b exp=01", sel); end
    got = 0; prev_err = err;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (upd !== 3'b000) got = 1;
      else prev_err = err;
    end
    checks++;
    if (!got) begin failures++; $display("FAIL tmo_recover got none exp ibat upd"); end
    else begin
      checks++;
      if (upd !== 3'b010 || err !== 1'b0 || prev_err !== 1'b1) begin
        failures++; $display("FAIL tmo_err_clear got upd=%b err=%b prev=%b exp 010/0/1", upd, err, prev_err);
      end
      checks++;
      if (sb.size() == 0) begin failures++; $display("FAIL tmo_sb got empty exp entry"); end
      else begin
        e = sb.pop_front();
        checks++;
        if (iq !== e.val || e.ch !== 2'd1) begin
          failures++; $display("FAIL tmo_ibat got=%h exp=%h", iq, e.val);
        end
      end
    end
    en = 0; mute_v = 0;
    repeat (6) @(negedge clk);
    clr_model();
  endtask

  task automatic test_cv();
    exp_t e; int chg, nupd, bad_sel; bit pend; logic [1:0] prev_sel; logic [2:0] last_upd;
    logic [7:0] q;
    sb.delete(); mode = 0; vm = 0; im = 1; tm = 1; en = 1;
    prev_sel = sel; chg = 0; pend = 0; nupd = 0; bad_sel = 0; last_upd = 3'b000;
    for (int n = 0; n < 400 && nupd < 4; n++) begin
      @(negedge clk);
      if (sel === 2'b00 || sel === 2'b11) bad_sel++;
      if (sel !== prev_sel) begin chg = n; pend = 1; end
      prev_sel = sel;
      if (st === 1'b1 && pend) begin
        pend = 0;
        checks++;
        if (n - chg != 2) begin failures++; $display("FAIL cv_settle got=%0d exp=2", n - chg); end
      end
      if (upd !== 3'b000) begin
        checks++;
        if (!(upd === 3'b010 || upd === 3'b100) || upd === last_upd) begin
          failures++; $display("FAIL cv_alternate got=%b prev=%b exp other of 010/100", upd, last_upd);
        end
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL cv_sb got empty exp entry"); end
        else begin
          e = sb.pop_front();
          q = (e.ch == 2'd1) ? iq : tq;
          checks++;
          if (upd !== (3'b001 << e.ch) || q !== e.val) begin
            failures++; $display("FAIL cv_result got upd=%b q=%h exp ch=%0d val=%h", upd, q, e.ch, e.val);
          end
        end
        last_upd = upd; nupd++;
      end
    end
    checks++;
    if (nupd != 4 || bad_sel != 0) begin
      failures++; $display("FAIL cv_run got upds=%0d badsel=%0d exp 4/0", nupd, bad_sel);
    end
    en = 0;
    repeat (6) @(negedge clk);
    clr_model();
  endtask

  task automatic test_abort();
    exp_t e; bit got; int ns, bad; logic [7:0] i_prev;
    sb.delete(); mode = 2; vm = 0; im = 1; tm = 0; en = 1;
    got = 0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (upd !== 3'b000) got = 1;
    end
    checks++;
    if (!got || sb.size() == 0) begin failures++; $display("FAIL abort_first got none exp ibat upd"); end
    else begin
      e = sb.pop_front();
      checks++;
      if (upd !== 3'b010 || iq !== e.val) begin
        failures++; $display("FAIL abort_first_val got upd=%b iq=%h exp 010/%h", upd, iq, e.val);
      end
    end
    i_prev = iq;
    ns = 0;
    for (int n = 0; n < 200 && ns < 3; n++) begin
      @(negedge clk);
      if (st === 1'b1 && sel === 2'b01) ns++;
    end
    checks++;
    if (ns != 3) begin failures++; $display("FAIL abort_third got=%0d starts exp=3", ns); end
    en = 0;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (upd !== 3'b000 || st !== 1'b0 || iq !== i_prev) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL abort_idle got=%0d bad cycles exp=0", bad); end
    clr_model();
    en = 1; ns = 0; got = 0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (st === 1'b1) ns++;
      if (upd !== 3'b000) got = 1;
    end
    checks++;
    if (!got || ns != 4) begin failures++; $display("FAIL abort_restart got starts=%0d exp=4", ns); end
    checks++;
    if (sb.size() == 0) begin failures++; $display("FAIL abort_sb got empty exp entry"); end
    else begin
      e = sb.pop_front();
      checks++;
      if (upd !== 3'b010 || iq !== e.val) begin
        failures++; $display("FAIL abort_restart_val got upd=%b iq=%h exp 010/%h", upd, iq, e.val);
      end
    end
    en = 0;
    repeat (6) @(negedge clk);
    clr_model();
  endtask

  task automatic test_areset();
    bit found;
    sb.delete(); mode = 0; vm = 1; im = 1; tm = 0; en = 1;
    found = 0;
    for (int n = 0; n < 300 && !found; n++) begin
      @(negedge clk);
      if (st === 1'b1 && sel === 2'b01) found = 1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL areset_setup got none exp ibat start"); end
    @(negedge clk);
    #1 rstz = 1'b0;
    #1;
    checks++;
    if ({st, sel, vq, iq, tq, upd, err} !== '0) begin
      failures++; $display("FAIL areset_outputs got=%h exp=0", {st, sel, vq, iq, tq, upd, err});
    end
    #2 rstz = 1'b1;
    m_clr = 1'b1;
    @(negedge clk);
    m_clr = 1'b0;
    found = 0;
    for (int n = 0; n < 50 && !found; n++) begin
      if (st === 1'b1) found = 1;
      else @(negedge clk);
    end
    checks++;
    if (!found || sel !== 2'b00) begin
      failures++; $display("FAIL areset_ptr got sel=%b exp=00", sel);
    end
    en = 0;
    repeat (6) @(negedge clk);
    clr_model();
  endtask

  task automatic test_avg();
    exp_t e; bit got; int nu;
    sb.delete(); dut_sel = 1; mode = 1; vm = 1; im = 0; tm = 0; en4 = 1;
    got = 0;
    for (int n = 0; n < 400 && !got; n++) begin
      @(negedge clk);
      if (upd4 !== 3'b000) got = 1;
    end
    checks++;
    if (!got || upd4 !== 3'b001 || vq4 !== 8'hFF) begin
      failures++; $display("FAIL avg16_ff got upd=%b q=%h exp 001/ff", upd4, vq4);
    end
    checks++;
    if (sb.size() == 0) begin failures++; $display("FAIL avg16_sb got empty exp entry"); end
    else begin
      e = sb.pop_front();
      checks++;
      if (vq4 !== e.val) begin failures++; $display("FAIL avg16_val got=%h exp=%h", vq4, e.val); end
    end
    en4 = 0;
    repeat (6) @(negedge clk);
    clr_model();
    dut_sel = 2; mode = 2; en0 = 1; nu = 0;
    for (int n = 0; n < 200 && nu < 3; n++) begin
      @(negedge clk);
      if (upd0 !== 3'b000) begin
        nu++;
        checks++;
        if (upd0 !== 3'b001 || vq0 !== data) begin
          failures++; $display("FAIL avg1_pass got upd=%b q=%h exp 001/%h", upd0, vq0, data);
        end
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL avg1_sb got empty exp entry"); end
        else begin
          e = sb.pop_front();
          checks++;
          if (vq0 !== e.val) begin failures++; $display("FAIL avg1_val got=%h exp=%h", vq0, e.val); end
        end
      end
    end
    checks++;
    if (nu != 3) begin failures++; $display("FAIL avg1_count got=%0d exp=3", nu); end
    en0 = 0;
    repeat (4) @(negedge clk);
    dut_sel = 0;
  endtask

  initial begin
    test_reset();
    test_vbat();
    test_timeout();
    test_cv();
    test_abort();
    test_areset();
    test_avg();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
